mips_multicycle_controller: RTL and testbench

//  Moore FSM sequencing the shared-memory multicycle MIPS datapath: one memory port for instruction
//  and data, one ALU for PC increment, address calc and execute. Decodes op/funct across states,

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mips_multicycle_controller_if.sv | 49 ++++
 rtl/mips_multicycle_controller_alu_decoder.sv | 33 +++
 rtl/mips_multicycle_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS controller.
//   - opcode and funct field encodings
//   - alu_op_t: main-controller to alu_decoder command (add, sub, use funct)
//   - alu_control encodings driven to the ALU
//   - mc_state_t: controller FSM states (also exported as a debug output)
// Optional feature macro: MC_BNE_EN (adds bne to the legal opcode set).
package mips_pkg;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } mc_state_t;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// mips_multicycle_controller_if: control bundle between the multicycle
// controller and the shared-memory datapath.
//   Datapath -> controller: op, funct, zero, mem_ready
//   Controller -> datapath: mem_req, iord, mem_write, ir_write, pc_en,
//     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
//     alu_control, instr_done, illegal_op, mem_timeout, state (debug)
// Memory handshake: the controller holds mem_req high for every cycle it
// needs the memory port; a transfer happens in exactly the cycle where
// mem_req and mem_ready are both high. mem_ready without mem_req is ignored.
// Modports: master = controller, slave = datapath.
interface mips_multicycle_controller_if;
    import mips_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
    mc_state_t  state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, pc_en, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
               instr_done, illegal_op, mem_timeout, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, pc_en, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
               instr_done, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// alu_decoder: translates the main controller's alu_op and the R-type
// funct field into the 3-bit ALU control word.
//   funct       in  6  instr[5:0]
//   alu_op      in  2  add / sub / decode funct
//   alu_control out 3  ALU operation select
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  alu_op_t    alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing a multicycle MIPS datapath
// with a single shared memory port and a single ALU.
//   clk    in  clock, all state on rising edge
//   reset  in  synchronous, active-high; forces every output to 0
//   bus    mips_multicycle_controller_if.master (op/funct/zero/mem_ready in,
//          mux selects, write enables, status pulses and debug state out)
// Parameter MEM_WAIT_MAX: unanswered mem_req cycles before the access is
// abandoned and the FSM restarts at FETCH (0 disables the timeout).
// Optional macro MC_BNE_EN: decodes bne (op 000101) as a branch on ~zero.
module mips_multicycle_controller
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    mips_multicycle_controller_if.master        bus
);

    // At least one bit so MEM_WAIT_MAX = 0 still elaborates.
    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] CNT_LAST = (MEM_WAIT_MAX > 0) ? CW'(MEM_WAIT_MAX - 1) : '0;

    mc_state_t     state;
    mc_state_t     state_next;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout;
    logic          op_illegal;

    // Internal (pre-reset-gating) control values
    logic          mem_req, iord, mem_write, ir_write, pc_write, branch, bne;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b, pc_src;
    logic          instr_done, pc_en;
    alu_op_t       alu_op;
    logic [2:0]    alu_ctl;

    assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                     && !bus.mem_ready;

    // The abort fires on the MEM_WAIT_MAX-th consecutive unanswered cycle,
    // i.e. when the counter is about to reach MEM_WAIT_MAX.
    assign timeout = (MEM_WAIT_MAX > 0) && waiting && (wait_cnt == CNT_LAST);

    alu_decoder u_alu_decoder (
        .funct       (bus.funct),
        .alu_op      (alu_op),
        .alu_control (alu_ctl)
    );

    // Next-state logic
    always_comb begin
        state_next = state;
        op_illegal = 1'b0;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = S_BRANCH;
`endif
                    OP_ADDI:      state_next = S_ADDIEXEC;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        op_illegal = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR:   state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWR:    if (bus.mem_ready) state_next = S_FETCH;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_ADDIEXEC: state_next = S_ADDIWB;
            S_ADDIWB:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
        // A timed-out access restarts from FETCH (a retry when already there).
        if (timeout) state_next = S_FETCH;
    end

    // State register and memory wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || !waiting || timeout) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Output decode from state, op and mem_ready
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_OP_ADD;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_write  = bus.mem_ready;
                instr_done = bus.mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_SUB;
                pc_src     = 2'b01;
                instr_done = 1'b1;
`ifdef MC_BNE_EN
                branch     = (bus.op != OP_BNE);
                bne        = (bus.op == OP_BNE);
`else
                branch     = 1'b1;
`endif
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        pc_en = pc_write | (branch & bus.zero) | (bne & ~bus.zero);
    end

    // Reset forces every control output low, abandoning any instruction.
    always_comb begin
        bus.state = state;
        if (reset) begin
            bus.mem_req     = 1'b0;
            bus.iord        = 1'b0;
            bus.mem_write   = 1'b0;
            bus.ir_write    = 1'b0;
            bus.pc_en       = 1'b0;
            bus.reg_write   = 1'b0;
            bus.reg_dst     = 1'b0;
            bus.mem_to_reg  = 1'b0;
            bus.alu_src_a   = 1'b0;
            bus.alu_src_b   = 2'b00;
            bus.pc_src      = 2'b00;
            bus.alu_control = 3'b000;
            bus.instr_done  = 1'b0;
            bus.illegal_op  = 1'b0;
            bus.mem_timeout = 1'b0;
        end else begin
            bus.mem_req     = mem_req;
            bus.iord        = iord;
            bus.mem_write   = mem_write;
            bus.ir_write    = ir_write;
            bus.pc_en       = pc_en;
            bus.reg_write   = reg_write;
            bus.reg_dst     = reg_dst;
            bus.mem_to_reg  = mem_to_reg;
            bus.alu_src_a   = alu_src_a;
            bus.alu_src_b   = alu_src_b;
            bus.pc_src      = pc_src;
            bus.alu_control = alu_ctl;
            bus.instr_done  = instr_done;
            bus.illegal_op  = op_illegal;
            bus.mem_timeout = timeout;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Testbench for mips_multicycle_controller. The driver walks instructions
// through a cycle-level reference of the controller's published behaviour,
// pushing one expected control word per cycle; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_mips_multicycle_controller;
  import mips_pkg::*;

  localparam int WAIT_MAX = 4;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } ctl_t;

  localparam int W = $bits(ctl_t);

  logic clk;
  logic reset;
  logic [W-1:0] exp_q[$];
  string name_q[$];
  int checks = 0;
  int fails = 0;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference helpers ----------------
  function automatic ctl_t base();
    ctl_t c;
    c = '0;
    c.alu_control = 3'b010;
    return c;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] o);
    if (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
        o == 6'b000100 || o == 6'b001000 || o == 6'b000010) return 1'b1;
`ifdef MC_BNE_EN
    if (o == 6'b000101) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.mem_req     = bus.mem_req;
    c.iord        = bus.iord;
    c.mem_write   = bus.mem_write;
    c.ir_write    = bus.ir_write;
    c.pc_en       = bus.pc_en;
    c.reg_write   = bus.reg_write;
    c.reg_dst     = bus.reg_dst;
    c.mem_to_reg  = bus.mem_to_reg;
    c.alu_src_a   = bus.alu_src_a;
    c.alu_src_b   = bus.alu_src_b;
    c.pc_src      = bus.pc_src;
    c.alu_control = bus.alu_control;
    c.instr_done  = bus.instr_done;
    c.illegal_op  = bus.illegal_op;
    c.mem_timeout = bus.mem_timeout;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: apply mem_ready, queue the expected outputs for it.
  task automatic step(input ctl_t e, input string nm, input logic ready);
    bus.mem_ready = ready;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Memory access phase. kind: 0 fetch, 1 load, 2 store. n_wait unanswered
  // cycles precede the ready cycle. Every WAIT_MAX-th consecutive unanswered
  // cycle times out: fetch retries, data accesses abandon (done = 0).
  task automatic mem_phase(input int kind, input int n_wait, input string nm, output bit done);
    ctl_t e;
    int cnt;
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i <= n_wait; i++) begin
      e = base();
      e.mem_req = 1'b1;
      if (kind == 0) e.alu_src_b = 2'b01;
      else e.iord = 1'b1;
      if (i == n_wait) begin
        if (kind == 0) begin
          e.ir_write = 1'b1;
          e.pc_en = 1'b1;
        end else if (kind == 2) begin
          e.mem_write = 1'b1;
          e.instr_done = 1'b1;
        end
        step(e, nm, 1'b1);
        done = 1'b1;
      end else begin
        cnt++;
        if (cnt == WAIT_MAX) begin
          e.mem_timeout = 1'b1;
          cnt = 0;
          step(e, {nm, " timeout"}, 1'b0);
          if (kind != 0) return;
        end else begin
          step(e, nm, 1'b0);
        end
      end
    end
  endtask

  task automatic decode_cycle(input logic [5:0] o);
    ctl_t e;
    e = base();
    e.alu_src_b = 2'b11;
    e.illegal_op = !op_known(o);
    step(e, "decode", 1'($urandom_range(0, 1)));
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int n_fetch, input int n_mem);
    ctl_t e;
    bit done;
    bus.op = o;
    bus.funct = f;
    bus.zero = z;
    mem_phase(0, n_fetch, "fetch", done);
    decode_cycle(o);
    if (!op_known(o)) return;
    e = base();
    if (o == 6'b100011 || o == 6'b101011) begin
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b10;
      step(e, "memadr", 1'($urandom_range(0, 1)));
      if (o == 6'b101011) begin
        mem_phase(2, n_mem, "sw memwr", done);
      end else begin
        mem_phase(1, n_mem, "lw memrd", done);
        if (done) begin
          e = base();
          e.mem_to_reg = 1'b1;
          e.reg_write = 1'b1;
          e.instr_done = 1'b1;
          step(e, "lw memwb", 1'($urandom_range(0, 1)));
        end
      end
    end else if (o == 6'b000000) begin
      e.alu_src_a = 1'b1;
      e.alu_control = ref_alu(f);
      step(e, "r execute", 1'($urandom_range(0, 1)));
      e = base();
      e.reg_dst = 1'b1;
      e.reg_write = 1'b1;
      e.instr_done = 1'b1;
      step(e, "r aluwb", 1'($urandom_range(0, 1)));
    end else if (o == 6'b000100 || o == 6'b000101) begin
      e.alu_src_a = 1'b1;
      e.alu_control = 3'b110;
      e.pc_src = 2'b01;
      e.instr_done = 1'b1;
      e.pc_en = (o == 6'b000100) ? z : ~z;
      step(e, "branch", 1'($urandom_range(0, 1)));
    end else if (o == 6'b001000) begin
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b10;
      step(e, "addi exec", 1'($urandom_range(0, 1)));
      e = base();
      e.reg_write = 1'b1;
      e.instr_done = 1'b1;
      step(e, "addi wb", 1'($urandom_range(0, 1)));
    end else begin
      e.pc_src = 2'b10;
      e.pc_en = 1'b1;
      e.instr_done = 1'b1;
      step(e, "jump", 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step('0, "reset", 1'($urandom_range(0, 1)));
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    ctl_t e;
    ctl_t a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s: got %05h required %05h (t=%0t, state %s)",
                   nm, a, e, $time, bus.state.name());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    ctl_t e;
    bit done;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b001000, 6'b000010, 6'b000101, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1;
    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then first fetch with memory ready
    reset_cycles(2);
    run_instr(6'b100011, 6'b0, 1'b0, 0, 0);          // lw, zero-wait
    run_instr(6'b101011, 6'b0, 1'b0, 0, 3);          // sw, 3 waits in MEMWR
    run_instr(6'b000100, 6'b0, 1'b1, 0, 0);          // beq taken
    run_instr(6'b000100, 6'b0, 1'b0, 0, 0);          // beq not taken
    run_instr(6'b000101, 6'b0, 1'b0, 0, 0);          // bne / illegal
    run_instr(6'b000101, 6'b0, 1'b1, 0, 0);
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);     // R slt
    run_instr(6'b001000, 6'b0, 1'b0, 1, 0);          // addi
    run_instr(6'b000010, 6'b0, 1'b0, 0, 0);          // j
    run_instr(6'b000010, 6'b0, 1'b0, 9, 0);          // fetch times out twice
    run_instr(6'b100011, 6'b0, 1'b0, 0, 4);          // lw read times out
    run_instr(6'b101011, 6'b0, 1'b0, 0, 6);          // sw write times out

    // Reset in the middle of a load: abandon without writes
    bus.op = 6'b100011;
    mem_phase(0, 0, "fetch", done);
    decode_cycle(6'b100011);
    e = base();
    e.alu_src_a = 1'b1;
    e.alu_src_b = 2'b10;
    step(e, "memadr", 1'b1);
    reset_cycles(1);
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      checks++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
